// File: rtl/trb_burst_reader.sv
// Burst read controller for the trace-buffer BRAM. It issues addresses, tracks the two-stage
// read pipeline and buffers returned words in a 4-entry FIFO that feeds a valid/ready stream.
module trb_burst_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]     remaining_q, remaining_d;
    logic                    p1_valid_q, p1_valid_d;
    logic                    p1_last_q, p1_last_d;
    logic                    p2_valid_q, p2_valid_d;
    logic                    p2_last_q, p2_last_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q [4];
    logic [DATA_WIDTH-1:0]   fifo_data_d [4];
    logic [3:0]              fifo_last_q, fifo_last_d;
    logic [1:0]              wr_ptr_q, wr_ptr_d;
    logic [1:0]              rd_ptr_q, rd_ptr_d;
    logic [2:0]              fifo_count_q, fifo_count_d;

    logic                    push;
    logic                    pop;
    logic [2:0]              occupancy;

    assign dout       = fifo_data_q[rd_ptr_q];
    assign dout_valid = (fifo_count_q != 3'd0);
    assign dout_last  = dout_valid & fifo_last_q[rd_ptr_q];
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign rd_addr    = rd_addr_q;

    assign push = p2_valid_q;
    assign pop  = dout_valid & dout_ready;
    // Words already committed to FIFO space: buffered plus both pipeline stages.
    assign occupancy = fifo_count_q + {2'b00, p1_valid_q} + {2'b00, p2_valid_q};

    always_comb begin
        state_d      = state_q;
        rd_addr_d    = rd_addr_q;
        remaining_d  = remaining_q;
        p1_valid_d   = 1'b0;
        p1_last_d    = 1'b0;
        p2_valid_d   = p1_valid_q;
        p2_last_d    = p1_last_q;
        done_d       = 1'b0;
        fifo_data_d  = fifo_data_q;
        fifo_last_d  = fifo_last_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;

        if (push) begin
            fifo_data_d[wr_ptr_q] = rd_data;
            fifo_last_d[wr_ptr_q] = p2_last_q;
            wr_ptr_d              = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + 3'd1;
        end else if (!push && pop) begin
            fifo_count_d = fifo_count_q - 3'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = S_FETCH;
                        rd_addr_d   = start_addr;
                        remaining_d = length - LEN_ONE;
                        p1_valid_d  = 1'b1;
                        p1_last_d   = (length == LEN_ONE);
                    end
                end
            end
            S_FETCH: begin
                if (remaining_q == '0) begin
                    state_d = S_DRAIN;
                end else if (occupancy < 3'd4) begin
                    rd_addr_d   = rd_addr_q + ADDR_ONE;
                    remaining_d = remaining_q - LEN_ONE;
                    p1_valid_d  = 1'b1;
                    p1_last_d   = (remaining_q == LEN_ONE);
                    if (remaining_q == LEN_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && fifo_last_q[rd_ptr_q]) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a start or a final transfer in the same cycle.
        if (abort) begin
            state_d      = S_IDLE;
            remaining_d  = '0;
            p1_valid_d   = 1'b0;
            p1_last_d    = 1'b0;
            p2_valid_d   = 1'b0;
            p2_last_d    = 1'b0;
            done_d       = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
            rd_addr_d    = rd_addr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            rd_addr_q    <= '0;
            remaining_q  <= '0;
            p1_valid_q   <= 1'b0;
            p1_last_q    <= 1'b0;
            p2_valid_q   <= 1'b0;
            p2_last_q    <= 1'b0;
            done_q       <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            remaining_q  <= remaining_d;
            p1_valid_q   <= p1_valid_d;
            p1_last_q    <= p1_last_d;
            p2_valid_q   <= p2_valid_d;
            p2_last_q    <= p2_last_d;
            done_q       <= done_d;
            fifo_data_q  <= fifo_data_d;
            fifo_last_q  <= fifo_last_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

endmodule
